mc_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 32-bit MIPS-subset datapath (regfile, alu, inst_ram, data_ram, PC muxes).

---
 rtl/mc_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the MIPS-subset datapath: steps each instruction
// through fetch/decode/execute/memory/writeback, drives the datapath controls and counts retirements.
module mc_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             eq_zero,
    input  logic             mem_ready,
    output logic             inst_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dest,
    output logic             mem_to_reg,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             halted,
    output logic [1:0]       fault
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_ADDR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic [1:0]       fault_q, fault_d;
    logic             timed_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FETCH;
            wait_cnt_q    <= '0;
            retired_cnt_q <= '0;
            fault_q       <= FAULT_NONE;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            retired_cnt_q <= retired_cnt_d;
            fault_q       <= fault_d;
        end
    end

    // A ready memory in the final permitted wait cycle still wins over the timeout.
    assign timed_out = !mem_ready && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        fault_d    = fault_q;
        inst_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dest   = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                inst_req  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_HALT;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    6'h00:        state_d = S_EXEC_R;
                    6'h08:        state_d = S_EXEC_I;
                    6'h23, 6'h2B: state_d = S_ADDR;
                    6'h04:        state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    default: begin
                        state_d = S_HALT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                state_d   = S_WB_R;
                case (funct)
                    6'h20: alu_op = ALU_ADD;
                    6'h22: alu_op = ALU_SUB;
                    6'h24: alu_op = ALU_AND;
                    6'h25: alu_op = ALU_OR;
                    6'h2A: alu_op = ALU_SLT;
                    default: begin
                        state_d = S_HALT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dest  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (timed_out) begin
                    state_d = S_HALT;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timed_out) begin
                    state_d = S_HALT;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = eq_zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, retire};
    end

    assign retired_cnt = retired_cnt_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: each instruction is expanded by a phase-level model
// into the control words it should produce cycle by cycle, with randomized memory wait states.
module tb_mc_sequencer;

    localparam int TMO = 4;
    localparam int CW  = 4;

    typedef struct packed {
        logic       inst_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       retire;
        logic       halted;
        logic [1:0] fault;
    } ctrl_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [5:0]    opcode = '0;
    logic [5:0]    funct = '0;
    logic          eq_zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          inst_req, ir_write, pc_write, alu_src_a;
    logic [1:0]    pc_src, alu_src_b, fault;
    logic [2:0]    alu_op;
    logic          mem_read, mem_write, reg_write, reg_dest, mem_to_reg, retire, halted;
    logic [CW-1:0] retired_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int modelCnt    = 0;
    logic [1:0] modelFault = 2'b00;
    int cyc         = 0;
    int retiredAt   = 0;

    mc_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .eq_zero(eq_zero),
        .mem_ready(mem_ready), .inst_req(inst_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .reg_dest(reg_dest),
        .mem_to_reg(mem_to_reg), .retire(retire), .retired_cnt(retired_cnt),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic ctrl_t wFetch(input logic rdy);
        ctrl_t c = '0;
        c.inst_req  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = rdy;
        c.pc_write  = rdy;
        return c;
    endfunction

    function automatic ctrl_t wHalt();
        ctrl_t c = '0;
        c.halted = 1'b1;
        c.fault  = modelFault;
        return c;
    endfunction

    function automatic logic isLegalFunct(input logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
    endfunction

    function automatic logic isLegalOp(input logic [5:0] op);
        return op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then compare the control word and count.
    task automatic applyStimulus(input string tag, input logic rdy, input logic eqz, input ctrl_t exp);
        ctrl_t obs;
        @(negedge clk);
        mem_ready = rdy;
        eq_zero   = eqz;
        #1;
        obs = '{inst_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
                mem_read, mem_write, reg_write, reg_dest, mem_to_reg, retire, halted, fault};
        cyc++;
        if (retire === 1'b1) retiredAt = cyc;
        checkOutput({tag, "_ctrl"}, {12'b0, obs}, {12'b0, exp});
        checkOutput({tag, "_cnt"}, 32'(retired_cnt), 32'(modelCnt));
        if (exp.retire) modelCnt = (modelCnt + 1) % (1 << CW);
    endtask

    // Asserts reset between edges and checks that it acts before any clock edge.
    task automatic doReset();
        #1;
        mem_ready = 1'b0;
        rst = 1'b1;
        modelCnt   = 0;
        modelFault = 2'b00;
        #1;
        checkOutput("reset_ctrl",
                    {12'b0, inst_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
                     mem_read, mem_write, reg_write, reg_dest, mem_to_reg, retire, halted, fault},
                    {12'b0, wFetch(1'b0)});
        checkOutput("reset_cnt", 32'(retired_cnt), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic enterHalt(input logic [1:0] f);
        modelFault = f;
        for (int k = 0; k < 3; k++) applyStimulus("halt", rbit(), rbit(), wHalt());
        doReset();
    endtask

    task automatic memPhase(input string tag, input ctrl_t waitWord, input ctrl_t readyWord,
                            input int waits, output logic ok);
        ok = 1'b1;
        for (int i = 0; i < waits; i++) begin
            applyStimulus(tag, 1'b0, rbit(), waitWord);
            if (i == TMO - 1) begin
                enterHalt(2'b10);
                ok = 1'b0;
                return;
            end
        end
        applyStimulus(tag, 1'b1, rbit(), readyWord);
    endtask

    // Expands one instruction into its expected phases and checks total latency on retirement.
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                            input int mw, input logic eqz);
        ctrl_t c;
        ctrl_t r;
        logic  ok;
        int    lat;
        opcode    = op;
        funct     = fn;
        cyc       = 0;
        retiredAt = 0;
        lat       = 0;
        memPhase("fetch", wFetch(1'b0), wFetch(1'b1), fw, ok);
        if (!ok) return;
        c = '0;
        c.alu_src_b = 2'b11;
        applyStimulus("decode", rbit(), rbit(), c);
        c = '0;
        case (op)
            6'h00: begin
                c.alu_src_a = 1'b1;
                case (fn)
                    6'h22:   c.alu_op = 3'b001;
                    6'h24:   c.alu_op = 3'b010;
                    6'h25:   c.alu_op = 3'b011;
                    6'h2A:   c.alu_op = 3'b100;
                    default: c.alu_op = 3'b000;
                endcase
                applyStimulus("exec_r", rbit(), rbit(), c);
                if (!isLegalFunct(fn)) begin
                    enterHalt(2'b01);
                    return;
                end
                c = '0;
                c.reg_write = 1'b1;
                c.reg_dest  = 1'b1;
                c.retire    = 1'b1;
                applyStimulus("wb_r", rbit(), rbit(), c);
                lat = 4;
            end
            6'h08: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                applyStimulus("exec_i", rbit(), rbit(), c);
                c = '0;
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
                applyStimulus("wb_i", rbit(), rbit(), c);
                lat = 4;
            end
            6'h23, 6'h2B: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                applyStimulus("addr", rbit(), rbit(), c);
                c = '0;
                if (op == 6'h23) begin
                    c.mem_read = 1'b1;
                    memPhase("mem_rd", c, c, mw, ok);
                    if (!ok) return;
                    c = '0;
                    c.reg_write  = 1'b1;
                    c.mem_to_reg = 1'b1;
                    c.retire     = 1'b1;
                    applyStimulus("wb_mem", rbit(), rbit(), c);
                    lat = 5;
                end else begin
                    c.mem_write = 1'b1;
                    r = c;
                    r.retire = 1'b1;
                    memPhase("mem_wr", c, r, mw, ok);
                    if (!ok) return;
                    lat = 4;
                end
            end
            6'h04: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'b001;
                c.pc_src    = 2'b01;
                c.pc_write  = eqz;
                c.retire    = 1'b1;
                applyStimulus("branch", rbit(), eqz, c);
                lat = 3;
            end
            6'h02: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b10;
                c.retire   = 1'b1;
                applyStimulus("jump", rbit(), rbit(), c);
                lat = 3;
            end
            default: begin
                enterHalt(2'b01);
                return;
            end
        endcase
        checkOutput("latency", 32'(retiredAt), 32'(lat + fw + ((op == 6'h23 || op == 6'h2B) ? mw : 0)));
    endtask

    function automatic int pickWaits();
        return ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, TMO - 1);
    endfunction

    initial begin
        ctrl_t c;
        logic [5:0] op;
        logic [5:0] fn;
        int pick;
        rst = 1'b1;
        doReset();

        runInstr(6'h00, 6'h20, 0, 0, 1'b0);
        runInstr(6'h23, 6'h00, 0, 3, 1'b0);
        runInstr(6'h04, 6'h00, 0, 0, 1'b1);
        runInstr(6'h04, 6'h00, 0, 0, 1'b0);

        // Abandon a load in the middle of its memory wait.
        opcode = 6'h23;
        cyc = 0;
        applyStimulus("mid_fetch", 1'b1, 1'b0, wFetch(1'b1));
        c = '0;
        c.alu_src_b = 2'b11;
        applyStimulus("mid_decode", 1'b0, 1'b0, c);
        c = '0;
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        applyStimulus("mid_addr", 1'b0, 1'b0, c);
        c = '0;
        c.mem_read = 1'b1;
        applyStimulus("mid_mem_rd", 1'b0, 1'b0, c);
        doReset();

        runInstr(6'h2B, 6'h00, 1, 2, 1'b0);
        runInstr(6'h02, 6'h00, 0, 0, 1'b0);
        runInstr(6'h08, 6'h00, 2, 0, 1'b0);
        runInstr(6'h00, 6'h3F, 0, 0, 1'b0);
        runInstr(6'h3F, 6'h20, 0, 0, 1'b0);
        runInstr(6'h02, 6'h00, TMO, 0, 1'b0);
        runInstr(6'h02, 6'h00, TMO - 1, 0, 1'b0);
        runInstr(6'h23, 6'h00, 0, TMO, 1'b0);
        runInstr(6'h2B, 6'h00, 0, TMO - 1, 1'b0);
        for (int i = 0; i < 18; i++) runInstr(6'h02, 6'h00, 0, 0, 1'b0);

        for (int n = 0; n < 250; n++) begin
            pick = $urandom_range(0, 99);
            fn = 6'($urandom_range(0, 63));
            if (pick < 18) begin
                op = 6'h00;
                case ($urandom_range(0, 4))
                    0: fn = 6'h20;
                    1: fn = 6'h22;
                    2: fn = 6'h24;
                    3: fn = 6'h25;
                    default: fn = 6'h2A;
                endcase
            end else if (pick < 21) begin
                op = 6'h00;
                while (isLegalFunct(fn)) fn = 6'($urandom_range(0, 63));
            end else if (pick < 33) op = 6'h08;
            else if (pick < 48) op = 6'h23;
            else if (pick < 63) op = 6'h2B;
            else if (pick < 78) op = 6'h04;
            else if (pick < 96) op = 6'h02;
            else begin
                op = 6'($urandom_range(0, 63));
                while (isLegalOp(op)) op = 6'($urandom_range(0, 63));
            end
            runInstr(op, fn, pickWaits(), pickWaits(), rbit());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
